uart_rx: RTL and testbench

//   Receive side of the team UART: recovers 8N1 frames from the asynchronous rx line using a 16x oversampled tick.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_os_tick.sv | 30 +++
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, default rates and divider helpers
package uart_pkg;

  // FSM state encoding shared by the rx path
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int DEF_FRE        = 50_000_000;
  localparam int DEF_BAUD_RATE  = 9600;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  // Clocks per oversample tick, truncated so tx and rx agree on bit time
  function automatic int calc_os_div(input int fre, input int baud, input int os);
    return fre / (baud * os);
  endfunction

  // Terminal count of the tx baud_tick divider (one tick per bit)
  function automatic int calc_count_max(input int fre, input int baud);
    return fre / baud - 1;
  endfunction

endpackage

// File: rtl/uart_rx_os_tick.sv
// rtl/uart_rx_os_tick.sv - oversample tick divider with synchronous clear
import uart_pkg::*;

module uart_rx_os_tick #(
  parameter int OS_DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  logic [CW-1:0] cnt;

  // Free-running divider, restarted by clr so ticks line up with the start edge
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == CW'(OS_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(OS_DIV - 1));

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled 8N1 UART receiver; optional parity via UART_RX_PARITY_EN
import uart_pkg::*;

module uart_rx #(
  parameter int FRE        = DEF_FRE,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int OS_DIV = calc_os_div(FRE, BAUD_RATE, OVERSAMPLE);
  localparam int SW     = $clog2(OVERSAMPLE);
  localparam int BW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  uart_state_t          state;
  logic                 rx_s1, rx_s2, rx_h;
  logic                 start_fall;
  logic                 os_clr;
  logic                 tick;
  logic [SW-1:0]        s;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;

`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_ODD = 1'b0;
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  // Two-flop synchroniser plus history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_h  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_h  <= rx_s2;
    end
  end

  // Only a genuine 1->0 transition starts a frame, so a held-low break is ignored
  assign start_fall = rx_h & ~rx_s2;
  assign os_clr     = (state == IDLE) && start_fall;

  uart_rx_os_tick #(.OS_DIV(OS_DIV)) u_os_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (os_clr),
    .tick (tick)
  );

  // Frame FSM: samples mid-bit, assembles LSB-first, registers strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start_fall) begin
            state <= START;
            s     <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (s == SW'(OVERSAMPLE / 2 - 1)) begin
              if (rx_s2) begin
                // Glitch shorter than half a bit: drop it silently
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state   <= DATA;
                s       <= '0;
                bit_cnt <= '0;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == SW'(OVERSAMPLE - 1)) begin
              s     <= '0;
              shift <= {rx_s2, shift[DATA_BITS-1:1]};
              if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s == SW'(OVERSAMPLE - 1)) begin
              s       <= '0;
              par_bad <= ((^shift) ^ rx_s2) != PARITY_ODD;
              state   <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s == SW'(OVERSAMPLE - 1)) begin
              s     <= '0;
              state <= IDLE;
              busy  <= 1'b0;
              if (rx_s2) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err <= par_bad;
`endif
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized scoreboard bench for uart_rx
module tb_uart_rx;

  localparam int FRE  = 1_000_000;
  localparam int BAUD = 15625;
  localparam int OS   = 16;
  localparam int BIT  = OS * (FRE / (BAUD * OS));   // 64 clk per bit
  localparam int LAT_LO = (OS / 2 + 9 * OS) * (BIT / OS) - 8;
  localparam int LAT_HI = (OS / 2 + 9 * OS) * (BIT / OS) + 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    bit         perr;
    int         t0;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         cycle = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.FRE(FRE), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe the DUT presents
  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err)) begin
      if (rx_valid && frame_err) begin
        chk("valid_and_ferr_together", 1, 0);
      end else if (sb.size() == 0) begin
        chk("unexpected_strobe", {30'd0, rx_valid, frame_err}, 0);
      end else begin
        exp_t e;
        int   lat;
        e = sb.pop_front();
        lat = cycle - e.t0;
        chk("strobe_kind_ferr", int'(frame_err), int'(e.ferr));
        chk("rx_data", int'(rx_data), int'(e.data));
        chk("parity_err", int'(parity_err), int'(e.perr));
        tests++;
        if (lat < LAT_LO || lat > LAT_HI) begin
          fails++;
          $display("FAIL latency: got %0d expected %0d..%0d", lat, LAT_LO, LAT_HI);
        end
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; abort_bit in 0..7 pulses rst mid data bit and abandons the frame
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic par_b, input int abort_bit);
    exp_t e;
    if (abort_bit < 0) begin
      e.ferr = !stop_b;
      if (stop_b) last_good = d;
      e.data = last_good;
`ifdef UART_RX_PARITY_EN
      e.perr = stop_b && ((^d) ^ par_b);
`else
      e.perr = 1'b0;
`endif
      e.t0 = cycle;
      sb.push_back(e);
    end
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT / 2) @(negedge clk);
      if (i == 4) chk("busy_mid_frame", int'(busy), 1);
      if (i == abort_bit) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_outputs", {28'd0, rx_valid, frame_err, parity_err, busy}, 0);
        rx = 1'b1;
        return;
      end
      repeat (BIT - BIT / 2) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_b;
    repeat (BIT) @(negedge clk);
`endif
    rx = stop_b;
    repeat (BIT) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_strobes", {29'd0, rx_valid, frame_err, parity_err}, 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    idle(BIT);

    // Directed: plain byte
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    idle(2 * BIT);
    chk("busy_after_frame", int'(busy), 0);

    // Directed: glitch shorter than half a bit
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_on_false_start", int'(busy), 1);
    repeat (10) @(negedge clk);
    idle(BIT);
    chk("busy_after_false_start", int'(busy), 0);

    // Directed: frame error followed by a break
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    rx = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    chk("no_restart_on_break", int'(busy), 0);
    idle(2 * BIT);

    // Directed: back-to-back frames
    send_frame(8'h00, 1'b1, 1'b0, -1);
    send_frame(8'hFF, 1'b1, 1'b0, -1);
    idle(2 * BIT);

    // Directed: reset mid-frame then a fresh frame
    send_frame(8'h5A, 1'b1, 1'b0, 4);
    idle(12 * BIT);
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    idle(2 * BIT);

    // Directed: parity (parity bit ignored by 8N1 build)
    send_frame(8'h81, 1'b1, 1'b1, -1);
    idle(BIT);
    send_frame(8'h81, 1'b1, 1'b0, -1);
    idle(BIT);

    // Random frames with occasional framing errors and random gaps
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic       sb_bit;
      logic       pb;
      int         gap;
      d      = 8'($urandom);
      sb_bit = ($urandom_range(0, 5) != 0);
      pb     = 1'($urandom);
      send_frame(d, sb_bit, pb, -1);
      gap = sb_bit ? $urandom_range(0, 2 * BIT) : $urandom_range(BIT, 2 * BIT);
      if (gap > 0) idle(gap);
    end

    for (int w = 0; w < 2000 && sb.size() != 0; w++) @(negedge clk);
    idle(4 * BIT);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
